// File: rtl/pwm_cfg_pkg.sv
// pwm_cfg_pkg -- shared constants and types for the PWM configuration scheduler.
//   ADDR_*      : register map of the five configuration registers
//   NUM_REGS    : number of implemented registers
//   pwm_cfg_state_e : commit FSM state encoding
package pwm_cfg_pkg;

  localparam logic [3:0] ADDR_OUT_LO = 4'd0;
  localparam logic [3:0] ADDR_OUT_HI = 4'd1;
  localparam logic [3:0] ADDR_PWM_LO = 4'd2;
  localparam logic [3:0] ADDR_PWM_HI = 4'd3;
  localparam logic [3:0] ADDR_DUTY   = 4'd4;
  localparam int unsigned NUM_REGS   = 5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_COMMIT  = 2'd2
  } pwm_cfg_state_e;

endpackage

// File: rtl/pwm_timebase.sv
// pwm_timebase -- prescaled 8-bit PWM phase counter.
//   clk, rst          : clock, synchronous active-high reset
//   pwm_cnt_o [7:0]   : current PWM phase count, advances once every DIV clocks
//   period_start_o    : one-cycle pulse in the cycle pwm_cnt_o has wrapped 255->0
module pwm_timebase #(
  parameter int unsigned DIV = 3000
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] pwm_cnt_o,
  output logic       period_start_o
);

  localparam logic [15:0] DIV_M1 = 16'(DIV - 1);

  logic [15:0] presc_q, presc_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        ps_q, ps_d;

  always_comb begin
    presc_d = presc_q + 16'd1;
    cnt_d   = cnt_q;
    ps_d    = 1'b0;
    if (presc_q == DIV_M1) begin
      presc_d = '0;
      cnt_d   = cnt_q + 8'd1;
      // Registered so the pulse coincides with the cycle the count reads 0.
      ps_d    = (cnt_q == 8'hFF);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      cnt_q   <= '0;
      ps_q    <= 1'b0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      ps_q    <= ps_d;
    end
  end

  assign pwm_cnt_o      = cnt_q;
  assign period_start_o = ps_q;

endmodule

// File: rtl/pwm_cfg_scheduler.sv
// pwm_cfg_scheduler -- two-port register writer with shadow registers that are
// committed to the live outputs only at a PWM period boundary.
//   clk, rst                    : clock, synchronous active-high reset
//   a_req/a_addr/a_data/a_ack   : write port A (level req held until ack pulse)
//   b_req/b_addr/b_data/b_ack   : write port B (same protocol)
//   en_reg_* , pwm_duty_cycle   : live register values, addresses 0..4
//   pwm_cnt, period_start       : PWM timebase
//   commit_pending              : any shadow register still dirty
//   err_addr                    : pulse alongside ack for an accepted addr > 4
//   fsm_state_o                 : commit FSM state, for observation
// Handshake: a port is granted at an edge where its req is high, its ack is
// low and the FSM is not in COMMIT; ack pulses for exactly the following cycle.
// Optional macro PWM_CFG_IMMEDIATE_EN: addresses 0 and 1 write straight to the
// live outputs at the grant edge and never become dirty.
module pwm_cfg_scheduler
  import pwm_cfg_pkg::*;
#(
  parameter int unsigned DIV = 3000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           a_req,
  input  logic [3:0]     a_addr,
  input  logic [7:0]     a_data,
  output logic           a_ack,
  input  logic           b_req,
  input  logic [3:0]     b_addr,
  input  logic [7:0]     b_data,
  output logic           b_ack,
  output logic [7:0]     en_reg_out_7_0,
  output logic [7:0]     en_reg_out_15_8,
  output logic [7:0]     en_reg_pwm_7_0,
  output logic [7:0]     en_reg_pwm_15_8,
  output logic [7:0]     pwm_duty_cycle,
  output logic [7:0]     pwm_cnt,
  output logic           period_start,
  output logic           commit_pending,
  output logic           err_addr,
  output pwm_cfg_state_e fsm_state_o
);

  logic [7:0]     live_q   [NUM_REGS];
  logic [7:0]     live_d   [NUM_REGS];
  logic [7:0]     shadow_q [NUM_REGS];
  logic [7:0]     shadow_d [NUM_REGS];
  logic [NUM_REGS-1:0] dirty_q, dirty_d;
  pwm_cfg_state_e state_q, state_d;
  logic           a_ack_q, b_ack_q, err_q;
  logic           last_b_q, last_b_d;

  logic           elig_a, elig_b, grant_a, grant_b, grant_any, addr_ok;
  logic [3:0]     g_addr;
  logic [7:0]     g_data;

  pwm_timebase #(.DIV(DIV)) u_timebase (
    .clk           (clk),
    .rst           (rst),
    .pwm_cnt_o     (pwm_cnt),
    .period_start_o(period_start)
  );

  always_comb begin
    elig_a    = a_req && !a_ack_q && (state_q != ST_COMMIT);
    elig_b    = b_req && !b_ack_q && (state_q != ST_COMMIT);
    // Round-robin: on contention, A wins only if B was granted last.
    grant_a   = elig_a && (!elig_b || last_b_q);
    grant_b   = elig_b && !grant_a;
    grant_any = grant_a || grant_b;
    g_addr    = grant_b ? b_addr : a_addr;
    g_data    = grant_b ? b_data : a_data;
    addr_ok   = (g_addr <= ADDR_DUTY);
    last_b_d  = grant_any ? grant_b : last_b_q;

    live_d   = live_q;
    shadow_d = shadow_q;
    dirty_d  = dirty_q;
    state_d  = state_q;

    if (grant_any && addr_ok) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (g_addr == 4'(i)) begin
`ifdef PWM_CFG_IMMEDIATE_EN
          if (g_addr == ADDR_OUT_LO || g_addr == ADDR_OUT_HI) begin
            live_d[i] = g_data;
          end else begin
            shadow_d[i] = g_data;
            dirty_d[i]  = 1'b1;
          end
`else
          shadow_d[i] = g_data;
          dirty_d[i]  = 1'b1;
`endif
        end
      end
    end

    case (state_q)
      ST_IDLE:    if (dirty_q != '0) state_d = ST_PENDING;
      ST_PENDING: if (period_start) state_d = ST_COMMIT;
      ST_COMMIT: begin
        // Grants are blocked in COMMIT, so dirty_q cannot change under us here.
        for (int i = 0; i < NUM_REGS; i++) begin
          if (dirty_q[i]) live_d[i] = shadow_q[i];
        end
        dirty_d = '0;
        state_d = ST_IDLE;
      end
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        live_q[i]   <= '0;
        shadow_q[i] <= '0;
      end
      dirty_q  <= '0;
      state_q  <= ST_IDLE;
      a_ack_q  <= 1'b0;
      b_ack_q  <= 1'b0;
      err_q    <= 1'b0;
      last_b_q <= 1'b1;
    end else begin
      live_q   <= live_d;
      shadow_q <= shadow_d;
      dirty_q  <= dirty_d;
      state_q  <= state_d;
      a_ack_q  <= grant_a;
      b_ack_q  <= grant_b;
      err_q    <= grant_any && !addr_ok;
      last_b_q <= last_b_d;
    end
  end

  assign a_ack           = a_ack_q;
  assign b_ack           = b_ack_q;
  assign err_addr        = err_q;
  assign commit_pending  = |dirty_q;
  assign fsm_state_o     = state_q;
  assign en_reg_out_7_0  = live_q[ADDR_OUT_LO];
  assign en_reg_out_15_8 = live_q[ADDR_OUT_HI];
  assign en_reg_pwm_7_0  = live_q[ADDR_PWM_LO];
  assign en_reg_pwm_15_8 = live_q[ADDR_PWM_HI];
  assign pwm_duty_cycle  = live_q[ADDR_DUTY];

endmodule
